ucode_sequencer: RTL and testbench

Microprogrammed controller for the compare/ALU datapath. It drives the same 16-bit control word: cnt_alu [15:13], slc_mux_a [12:9], slc_mux_b [8:5], slc_reg [4:1] and w [0]. Instead of a hard-wired state table, it executes a small writable control store that a host loads while the block is idle. Conditional branches use the datapath flags `mayor` and `bandera`, and a hardware loop counter removes the need to unroll repeated passes.

---
 rtl/ucode_sequencer.sv | 126 ++++++++++++
 tb/tb_ucode_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ucode_sequencer.sv
// Writable-control-store sequencer driving the ALU/compare control word; one instruction per cycle,
// first word one cycle after start. No backpressure: flags are sampled in the issuing cycle.
module ucode_sequencer #(
    parameter int ADDR_W = 4,
    parameter int CW     = 16,
    parameter int LOOP_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [LOOP_W-1:0]       loop_init,
    input  logic                    mayor,
    input  logic                    bandera,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [CW+ADDR_W+2:0]    wr_data,
    output logic [CW-1:0]           o_signal,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_W-1:0]       pc_out,
    output logic                    wr_err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int EW    = CW + ADDR_W + 3;

    localparam logic [2:0] OP_HALT = 3'b000;
    localparam logic [2:0] OP_JMP  = 3'b010;
    localparam logic [2:0] OP_BRM  = 3'b011;
    localparam logic [2:0] OP_BRNM = 3'b100;
    localparam logic [2:0] OP_BRB  = 3'b101;
    localparam logic [2:0] OP_DJNZ = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   pc;
    logic [LOOP_W-1:0]   cnt;
    logic [EW-1:0]       store [DEPTH];

    logic [EW-1:0]       instr;
    logic [2:0]          op;
    logic [ADDR_W-1:0]   target;
    logic [CW-1:0]       ctrl;
    logic [ADDR_W-1:0]   pc_inc;
    logic [ADDR_W-1:0]   nxt_pc;
    logic [LOOP_W-1:0]   nxt_cnt;
    logic                halt;

    assign instr  = store[pc];
    assign ctrl   = instr[CW-1:0];
    assign target = instr[CW+ADDR_W-1:CW];
    assign op     = instr[EW-1:CW+ADDR_W];
    assign pc_inc = pc + ADDR_W'(1);

    // Next-instruction decision; the reserved opcode falls through as SEQ.
    always_comb begin
        nxt_pc  = pc_inc;
        nxt_cnt = cnt;
        halt    = 1'b0;
        case (op)
            OP_HALT: begin
                nxt_pc = pc;
                halt   = 1'b1;
            end
            OP_JMP:  nxt_pc = target;
            OP_BRM:  if (mayor)   nxt_pc = target;
            OP_BRNM: if (!mayor)  nxt_pc = target;
            OP_BRB:  if (bandera) nxt_pc = target;
            OP_DJNZ: begin
                if (cnt != '0) begin
                    nxt_cnt = cnt - LOOP_W'(1);
                    nxt_pc  = target;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            pc     <= '0;
            cnt    <= '0;
            wr_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) store[i] <= '0;
        end else begin
            if (wr_en) begin
                if (state == S_IDLE) store[wr_addr] <= wr_data;
                else                 wr_err         <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN;
                        pc    <= '0;
                        cnt   <= loop_init;
                    end
                end
                S_RUN: begin
                    // abort wins over every opcode, HALT included, and freezes pc/cnt
                    if (abort) begin
                        state <= S_IDLE;
                    end else begin
                        pc  <= nxt_pc;
                        cnt <= nxt_cnt;
                        if (halt) state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy     = (state == S_RUN);
    assign done     = (state == S_DONE);
    assign o_signal = busy ? ctrl : '0;
    assign pc_out   = pc;

endmodule

// File: tb/tb_ucode_sequencer.sv
// Scoreboarded bench for ucode_sequencer: a trace model fills the expected queue, a negedge monitor drains it.
module tb_ucode_sequencer;

    localparam int AW    = 4;
    localparam int CWD   = 16;
    localparam int LW    = 4;
    localparam int EW    = CWD + AW + 3;
    localparam int DEPTH = 1 << AW;
    localparam int MAXS  = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           abort;
    logic [LW-1:0]  loop_init;
    logic           mayor;
    logic           bandera;
    logic           wr_en;
    logic [AW-1:0]  wr_addr;
    logic [EW-1:0]  wr_data;
    logic [CWD-1:0] o_signal;
    logic           busy;
    logic           done;
    logic [AW-1:0]  pc_out;
    logic           wr_err;

    ucode_sequencer #(.ADDR_W(AW), .CW(CWD), .LOOP_W(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .loop_init (loop_init),
        .mayor     (mayor),
        .bandera   (bandera),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .o_signal  (o_signal),
        .busy      (busy),
        .done      (done),
        .pc_out    (pc_out),
        .wr_err    (wr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_done;
        int pc;
        int ctrl;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [EW-1:0] shadow [DEPTH];
    bit            fm [MAXS];
    bit            fb [MAXS];
    int            n_checks = 0;
    int            n_pass   = 0;
    int            n465     = 0;
    bit            mon_en   = 1'b1;

    task automatic chk(input string nm, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    endtask

    function automatic logic [EW-1:0] ent(input int op, input int tgt, input int ctl);
        return {3'(op), 4'(tgt), 16'(ctl)};
    endfunction

    // Architectural trace: what the control store should emit, step by step.
    task automatic model(input int li, input int lim, output int nsteps,
                         output bit aborted, output int last_pc);
        int   pc = 0;
        int   c  = li;
        int   op, tgt, ctl;
        bit   take;
        exp_t e;
        nsteps  = 0;
        aborted = 1'b0;
        last_pc = 0;
        for (int s = 0; s < MAXS; s++) begin
            op  = int'(shadow[pc][EW-1:CWD+AW]);
            tgt = int'(shadow[pc][CWD+AW-1:CWD]);
            ctl = int'(shadow[pc][CWD-1:0]);
            e.is_done = 1'b0; e.pc = pc; e.ctrl = ctl;
            exp_q.push_back(e);
            nsteps++;
            last_pc = pc;
            if (s == lim) begin
                aborted = 1'b1;
                break;
            end
            if (op == 0) begin
                e.is_done = 1'b1; e.pc = pc; e.ctrl = 0;
                exp_q.push_back(e);
                break;
            end
            take = (op == 2) || (op == 3 && fm[s]) || (op == 4 && !fm[s]) ||
                   (op == 5 && fb[s]) || (op == 6 && c > 0);
            if (op == 6 && c > 0) c = c - 1;
            pc = take ? tgt : (pc + 1) % DEPTH;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && (busy || done)) begin
            if (busy && o_signal == 16'h0465) n465++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_output: busy=%0b done=%0b pc=%0d osig=0x%0h, required no output",
                         busy, done, pc_out, o_signal);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_kind_done", int'(done), int'(mon_e.is_done));
                chk("out_pc", int'(pc_out), mon_e.pc);
                chk("out_osig", int'(o_signal), mon_e.ctrl);
            end
        end
    end

    task automatic wr(input int a, input logic [EW-1:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic load_prog();
        for (int a = 1; a < DEPTH; a++) wr(a, shadow[a]);
    endtask

    task automatic clear_prog();
        for (int a = 0; a < DEPTH; a++) shadow[a] = '0;
        for (int s = 0; s < MAXS; s++) begin fm[s] = 1'b0; fb[s] = 1'b0; end
    endtask

    // Address 0 is optionally written in the same cycle as start.
    task automatic run_prog(input int li, input int lim, input int wr_at, input bit wr0);
        int nsteps, last_pc;
        bit aborted;
        model(li, lim, nsteps, aborted, last_pc);
        @(negedge clk);
        start = 1'b1; loop_init = LW'(li);
        if (wr0) begin wr_en = 1'b1; wr_addr = '0; wr_data = shadow[0]; end
        @(posedge clk); #1;
        start = 1'b0; wr_en = 1'b0;
        for (int s = 0; s < nsteps; s++) begin
            mayor = fm[s]; bandera = fb[s];
            abort = aborted && (s == nsteps - 1);
            if (s == wr_at) begin
                wr_en = 1'b1; wr_addr = AW'(5); wr_data = ent(1, 0, 16'hbeef);
            end
            @(posedge clk); #1;
            wr_en = 1'b0; abort = 1'b0;
        end
        @(posedge clk); #1;
        chk("drain_exp_q", exp_q.size(), 0);
        chk("end_busy", int'(busy), 0);
        chk("end_done", int'(done), 0);
        chk("end_osig", int'(o_signal), 0);
        chk("end_pc", int'(pc_out), last_pc);
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0; loop_init = '0;
        mayor = 1'b0; bandera = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        clear_prog();
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_osig", int'(o_signal), 0);
        chk("rst_pc", int'(pc_out), 0);
        chk("rst_wr_err", int'(wr_err), 0);
        @(negedge clk); rst = 1'b1;

        // empty store: single HALT at address 0
        run_prog(0, MAXS - 1, -1, 1'b0);

        clear_prog();
        shadow[0] = ent(1, 0, 16'h0240);
        shadow[1] = ent(1, 0, 16'h0249);
        shadow[2] = ent(0, 0, 16'h0243);
        load_prog();
        run_prog(0, MAXS - 1, -1, 1'b1);

        clear_prog();
        shadow[0] = ent(3, 3, 16'h0460);
        load_prog();
        fm[0] = 1'b1;
        run_prog(0, MAXS - 1, -1, 1'b1);
        fm[0] = 1'b0;
        run_prog(0, MAXS - 1, -1, 1'b1);

        clear_prog();
        shadow[0] = ent(1, 0, 16'h0465);
        shadow[1] = ent(6, 0, 16'h0000);
        load_prog();
        n465 = 0;
        run_prog(3, MAXS - 1, -1, 1'b1);
        chk("djnz_0465_count", n465, 4);

        for (int t = 0; t < 40; t++) begin
            for (int a = 0; a < DEPTH; a++)
                shadow[a] = ent(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), int'($urandom));
            shadow[$urandom_range(1, 15)] = ent(0, 0, int'($urandom));
            for (int s = 0; s < MAXS; s++) begin
                fm[s] = 1'($urandom_range(0, 1));
                fb[s] = 1'($urandom_range(0, 1));
            end
            load_prog();
            run_prog(int'($urandom_range(0, 15)),
                     ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, MAXS - 1)) : MAXS - 1,
                     -1, 1'b1);
        end

        // infinite JMP loop stopped by abort
        clear_prog();
        shadow[0] = ent(2, 0, 16'h0123);
        load_prog();
        run_prog(0, 10, -1, 1'b1);

        clear_prog();
        shadow[0] = ent(1, 0, 16'h0011);
        shadow[1] = ent(2, 5, 16'h0022);
        shadow[5] = ent(0, 0, 16'h1234);
        load_prog();
        chk("wr_err_before", int'(wr_err), 0);
        run_prog(0, MAXS - 1, 0, 1'b1);
        chk("wr_err_after", int'(wr_err), 1);

        // reset mid-run must clear outputs, wr_err and the store
        clear_prog();
        shadow[0] = ent(2, 1, 16'h0777);
        shadow[1] = ent(2, 0, 16'h0778);
        load_prog();
        mon_en = 1'b0;
        @(negedge clk);
        start = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_data = shadow[0];
        @(posedge clk); #1;
        start = 1'b0; wr_en = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("mid_busy_pre", int'(busy), 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_osig", int'(o_signal), 0);
        chk("mid_rst_pc", int'(pc_out), 0);
        chk("mid_rst_wr_err", int'(wr_err), 0);
        @(negedge clk); rst = 1'b1;
        mon_en = 1'b1;
        clear_prog();
        run_prog(0, MAXS - 1, -1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
